// File: rtl/floorshift_log2_correct_pkg.sv
// floorshift_log2_pkg: shared constants and the elaboration-time generator for
// the log2 correction table used by floorshift_log2_correct.
//   INT_BITS    : width of the integer field of a log word (5)
//   corr_w()    : internal correction precision W = FRAC_BITS + 2
//   corr_entry(): C[k] = round((log2(1 + k/2^L) - k/2^L) * 2^W), and 0 for k = 2^L
// Optional feature macro honoured by the users of this package:
//   FLOORSHIFT_LOG2_CORRECT_INTERP_EN (linear interpolation between table entries)
package floorshift_log2_pkg;

    localparam int INT_BITS = 5;

    function automatic int corr_w(input int frac_bits);
        return frac_bits + 2;
    endfunction

    // Evaluated only at elaboration; the real arithmetic never reaches hardware.
    function automatic int corr_entry(input int frac_bits, input int lut_bits, input int k);
        real x;
        real e;
        if (k >= (1 << lut_bits)) begin
            return 0;
        end
        x = real'(k) / real'(1 << lut_bits);
        e = ($ln(1.0 + x) / $ln(2.0) - x) * real'(1 << corr_w(frac_bits));
        return $rtoi(e + 0.5);
    endfunction

endpackage

// File: rtl/floorshift_log2_correct_if.sv
// floorshift_log2_correct_if: sample stream into and out of the correction stage.
//   in_i    : upstream log word {integer[4:0], fraction[FRAC_BITS-1:0]}
//   valid_i : in_i is valid this cycle
//   out_o   : corrected log word, same format
//   valid_o : out_o is valid this cycle (no backpressure)
// master = producer/consumer side, slave = the correction stage.
interface floorshift_log2_correct_if #(
    parameter int FRAC_BITS = 8
);
    logic [FRAC_BITS+floorshift_log2_pkg::INT_BITS-1:0] in_i;
    logic                                               valid_i;
    logic [FRAC_BITS+floorshift_log2_pkg::INT_BITS-1:0] out_o;
    logic                                               valid_o;

    modport master (output in_i, output valid_i, input out_o, input valid_o);
    modport slave  (input in_i, input valid_i, output out_o, output valid_o);
endinterface

// File: rtl/floorshift_log2_correct_lut.sv
// log2_corr_lut: registered ROM holding the correction table (pipeline stage S2).
//   clk_i, rst_ni : clock, asynchronous active-low reset (outputs clear to 0)
//   idx_i         : table index (top LUT_BITS of the fraction)
//   c_lo_o        : C[idx], one clock after idx_i
//   c_hi_o        : C[idx+1], only with FLOORSHIFT_LOG2_CORRECT_INTERP_EN defined
// Without the macro only the single C[idx] read port exists.
module log2_corr_lut
    import floorshift_log2_pkg::*;
#(
    parameter int FRAC_BITS = 8,
    parameter int LUT_BITS  = 4,
    localparam int W        = corr_w(FRAC_BITS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [LUT_BITS-1:0] idx_i,
`ifdef FLOORSHIFT_LOG2_CORRECT_INTERP_EN
    output logic [W-1:0]        c_hi_o,
`endif
    output logic [W-1:0]        c_lo_o
);

`ifdef FLOORSHIFT_LOG2_CORRECT_INTERP_EN
    // One extra entry (always 0) so idx = max can read its upper neighbour.
    localparam int DEPTH = (1 << LUT_BITS) + 1;
`else
    localparam int DEPTH = (1 << LUT_BITS);
`endif

    logic [W-1:0] rom [0:DEPTH-1];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign rom[gi] = W'(corr_entry(FRAC_BITS, LUT_BITS, gi));
    end

    logic [W-1:0] c_lo_d, c_lo_q;

`ifdef FLOORSHIFT_LOG2_CORRECT_INTERP_EN
    logic [W-1:0]      c_hi_d, c_hi_q;
    logic [LUT_BITS:0] idx_lo, idx_hi;

    always_comb begin
        idx_lo = {1'b0, idx_i};
        idx_hi = idx_lo + (LUT_BITS+1)'(1);
        c_lo_d = rom[idx_lo];
        c_hi_d = rom[idx_hi];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_lo_q <= '0;
            c_hi_q <= '0;
        end else begin
            c_lo_q <= c_lo_d;
            c_hi_q <= c_hi_d;
        end
    end

    assign c_hi_o = c_hi_q;
`else
    always_comb begin
        c_lo_d = rom[idx_i];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_lo_q <= '0;
        end else begin
            c_lo_q <= c_lo_d;
        end
    end
`endif

    assign c_lo_o = c_lo_q;

endmodule

// File: rtl/floorshift_log2_correct.sv
// floorshift_log2_correct: adds the LUT correction log2(1+f) - f to the
// fractional part of a piecewise-linear log2 word. Fixed latency of 4 clocks,
// one sample per clock.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset; flushes every stage
//   bus    : slave side of floorshift_log2_correct_if (in_i/valid_i -> out_o/valid_o)
// Stages: S1 input register, S2 table read, S3 correction term, S4 add/round/saturate.
// FLOORSHIFT_LOG2_CORRECT_INTERP_EN defined: linear interpolation between
// C[idx] and C[idx+1]; undefined: step correction C[idx] (S3 is then a plain register).
module floorshift_log2_correct
    import floorshift_log2_pkg::*;
#(
    parameter int FRAC_BITS = 8,
    parameter int LUT_BITS  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    floorshift_log2_correct_if.slave bus
);

    localparam int W  = corr_w(FRAC_BITS);
    localparam int DW = FRAC_BITS + INT_BITS;
    localparam int SW = W + INT_BITS + 1;        // {word, 2'b00} plus one headroom bit
`ifdef FLOORSHIFT_LOG2_CORRECT_INTERP_EN
    localparam int SHIFT  = FRAC_BITS - LUT_BITS;
    localparam int R_BITS = (SHIFT > 0) ? SHIFT : 1;
    localparam int CW     = W + R_BITS + 2;      // holds (C[idx+1]-C[idx])*r signed
`else
    localparam int CW     = W + 1;
`endif

    logic [DW-1:0]        in1_d, in1_q, in2_d, in2_q, in3_d, in3_q, out_d, out_q;
    logic                 v1_d, v1_q, v2_d, v2_q, v3_d, v3_q, v4_d, v4_q;
    logic signed [CW-1:0] c3_d, c3_q;
    logic [W-1:0]         c_lo;
    logic [SW-1:0]        sum;
    logic [DW:0]          q_trunc, q_round;
    logic                 round_up;

`ifdef FLOORSHIFT_LOG2_CORRECT_INTERP_EN
    logic [W-1:0]         c_hi;
    logic [R_BITS-1:0]    r1, r2_d, r2_q;
    logic signed [CW-1:0] c_lo_s, c_hi_s, r_s, prod;

    // r is empty when the whole fraction indexes the table.
    if (SHIFT > 0) begin : g_r
        assign r1 = in1_q[R_BITS-1:0];
    end else begin : g_r0
        assign r1 = '0;
    end
`endif

    log2_corr_lut #(
        .FRAC_BITS(FRAC_BITS),
        .LUT_BITS (LUT_BITS)
    ) u_lut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .idx_i (in1_q[FRAC_BITS-1 -: LUT_BITS]),
`ifdef FLOORSHIFT_LOG2_CORRECT_INTERP_EN
        .c_hi_o(c_hi),
`endif
        .c_lo_o(c_lo)
    );

    always_comb begin
        in1_d = bus.in_i;
        v1_d  = bus.valid_i;
        in2_d = in1_q;
        v2_d  = v1_q;
        in3_d = in2_q;
        v3_d  = v2_q;
        v4_d  = v3_q;

`ifdef FLOORSHIFT_LOG2_CORRECT_INTERP_EN
        r2_d   = r1;
        c_lo_s = $signed(CW'(c_lo));
        c_hi_s = $signed(CW'(c_hi));
        r_s    = $signed(CW'(r2_q));
        prod   = (c_hi_s - c_lo_s) * r_s;
        // Arithmetic shift floors a negative slope contribution.
        c3_d   = c_lo_s + (prod >>> SHIFT);
`else
        c3_d   = $signed(CW'(c_lo));
`endif

        sum      = {1'b0, in3_q, 2'b00} + SW'(c3_q);
        q_trunc  = sum[SW-1:2];
        // Round half to even on the two dropped bits.
        round_up = sum[1] & (sum[0] | sum[2]);
        q_round  = q_trunc + (DW+1)'(round_up);
        out_d    = q_round[DW] ? '1 : q_round[DW-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in1_q <= '0;
            in2_q <= '0;
            in3_q <= '0;
            out_q <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            v4_q  <= 1'b0;
            c3_q  <= '0;
`ifdef FLOORSHIFT_LOG2_CORRECT_INTERP_EN
            r2_q  <= '0;
`endif
        end else begin
            in1_q <= in1_d;
            in2_q <= in2_d;
            in3_q <= in3_d;
            out_q <= out_d;
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            v4_q  <= v4_d;
            c3_q  <= c3_d;
`ifdef FLOORSHIFT_LOG2_CORRECT_INTERP_EN
            r2_q  <= r2_d;
`endif
        end
    end

    assign bus.out_o   = out_q;
    assign bus.valid_o = v4_q;

endmodule

// File: tb/tb_floorshift_log2_correct.sv
// tb_floorshift_log2_correct: random and directed stimulus for
// floorshift_log2_correct (FRAC_BITS=8, LUT_BITS=4). Expected words come from
// a real-arithmetic model of the correction; directed cases use fixed constants.
// Honours FLOORSHIFT_LOG2_CORRECT_INTERP_EN the same way as the design.
module tb_floorshift_log2_correct;

    localparam int FRAC_BITS = 8;
    localparam int LUT_BITS  = 4;
`ifdef FLOORSHIFT_LOG2_CORRECT_INTERP_EN
    localparam int EXP_INTERP = 'h25C;
`else
    localparam int EXP_INTERP = 'h25A;
`endif

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    int    cyc   = 0;
    int    n_vec = 0;
    int    n_err = 0;
    int    cref [0:16];
    int    due_q[$];
    int    exp_q[$];
    string tag_q[$];

    floorshift_log2_correct_if #(.FRAC_BITS(FRAC_BITS)) bus ();

    floorshift_log2_correct #(
        .FRAC_BITS(FRAC_BITS),
        .LUT_BITS (LUT_BITS)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: corrected log2 from the table definition, plain integer/real math.
    function automatic int model(input int word);
        int f, idx, r, c, s, q, rem;
        f   = word % 256;
        idx = f / 16;
        r   = f % 16;
`ifdef FLOORSHIFT_LOG2_CORRECT_INTERP_EN
        c = cref[idx] + $rtoi($floor(real'((cref[idx+1] - cref[idx]) * r) / 16.0));
`else
        c = cref[idx];
`endif
        s   = word * 4 + c;
        q   = s / 4;
        rem = s % 4;
        if (rem > 2 || (rem == 2 && (q % 2) == 1)) q++;
        if (q > 8191) q = 8191;
        return q;
    endfunction

    // One clock: check what the DUT shows now, then drive the next input.
    task automatic tick(input logic v, input int d, input int exp, input string tag);
        @(negedge clk);
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            check({tag_q[0], "_valid"}, int'(bus.valid_o), 1);
            check(tag_q[0], int'(bus.out_o), exp_q[0]);
            $display("txn %-10s cycle %0d out=0x%04h expected=0x%04h", tag_q[0], cyc, bus.out_o, exp_q[0]);
            void'(due_q.pop_front());
            void'(exp_q.pop_front());
            void'(tag_q.pop_front());
        end else begin
            check("idle_valid", int'(bus.valid_o), 0);
        end
        bus.valid_i = v;
        bus.in_i    = 13'(d);
        if (v && rst_n) begin
            due_q.push_back(cyc + 4);
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
    endtask

    task automatic send_rand(input string tag);
        int d;
        d = $urandom_range(0, 8191);
        tick(1'b1, d, model(d), tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        real x;
        for (int k = 0; k < 16; k++) begin
            x = real'(k) / 16.0;
            cref[k] = $rtoi(($ln(1.0 + x) / $ln(2.0) - x) * 1024.0 + 0.5);
        end
        cref[16] = 0;

        bus.valid_i = 1'b0;
        bus.in_i    = '0;

        // Reset state
        #1;
        check("rst_out", int'(bus.out_o), 0);
        check("rst_valid", int'(bus.valid_o), 0);
        repeat (3) @(negedge clk);
        check("rst_out_held", int'(bus.out_o), 0);
        rst_n = 1'b1;
        repeat (10) tick(1'b0, 0, 0, "idle");

        // Directed table/rounding/boundary cases
        tick(1'b1, 'h380, 'h396, "hit");
        repeat (5) tick(1'b0, 0, 0, "idle");
        tick(1'b1, 'h000, 'h000, "zero");
        tick(1'b1, 'h700, 'h700, "pow2");
        tick(1'b1, 'h240, 'h252, "half_even");
        tick(1'b1, 'h248, EXP_INTERP, "interp");
        tick(1'b1, 'h1FFF, 'h1FFF, "sat");
        tick(1'b1, 'h1FFE, model('h1FFE), "top_edge");
        tick(1'b1, 'h0FF, model('h0FF), "idx_max");
        repeat (6) tick(1'b0, 0, 0, "idle");

        // Random traffic with gaps
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) send_rand("rand");
            else tick(1'b0, $urandom_range(0, 8191), 0, "gap");
        end

        // 20 back-to-back samples
        for (int i = 0; i < 20; i++) send_rand("stream");
        repeat (6) tick(1'b0, 0, 0, "idle");

        // Reset pulse in cycle 2 of a burst: nothing in flight may emerge
        send_rand("burst");
        send_rand("burst");
        #2;
        rst_n = 1'b0;
        due_q.delete();
        exp_q.delete();
        tag_q.delete();
        #1;
        check("midrst_valid", int'(bus.valid_o), 0);
        check("midrst_out", int'(bus.out_o), 0);
        tick(1'b1, 'h123, 0, "in_reset");
        tick(1'b0, 0, 0, "in_reset");
        #2;
        rst_n = 1'b1;
        repeat (8) tick(1'b0, 0, 0, "idle");

        // Recovery after reset
        tick(1'b1, 'h380, 'h396, "post_rst");
        for (int i = 0; i < 5; i++) send_rand("post_rand");
        repeat (8) tick(1'b0, 0, 0, "idle");

        check("leftover_expected", due_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
